// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: pipeline stage register with a two-entry skid buffer.
// A main entry drives the D-side outputs; a skid entry absorbs the one extra
// instruction that can arrive while the downstream stage is stalled. readyC is
// taken straight from the skid valid flop, so there is no combinational stall
// path back upstream. All state changes on the falling edge of CLK.
// Optional feature macro: STAGE_BUF_PERF_EN builds saturating stall and flush
// counters; without it stall_cnt and flush_cnt read as zero.
module pipe_stage_buf #(
    parameter int PC_W    = 13,
    parameter int INST_W  = 32,
    parameter int STATE_W = 2,
    parameter int CNT_W   = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               validC,
    output logic               readyC,
    input  logic [PC_W-1:0]    pcC,
    input  logic [INST_W-1:0]  instC,
    input  logic [STATE_W-1:0] stateC,
    input  logic               fail_predict,
    output logic               validD,
    input  logic               readyD,
    output logic [PC_W-1:0]    pcD,
    output logic [INST_W-1:0]  instD,
    output logic [STATE_W-1:0] stateD,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    logic               main_vld;
    logic [PC_W-1:0]    main_pc;
    logic [INST_W-1:0]  main_inst;
    logic [STATE_W-1:0] main_st;

    logic               skid_vld;
    logic [PC_W-1:0]    skid_pc;
    logic [INST_W-1:0]  skid_inst;
    logic [STATE_W-1:0] skid_st;

    logic accept;
    logic transfer;

    assign readyC   = !skid_vld;
    assign accept   = validC && readyC;
    assign transfer = main_vld && readyD;

    assign validD = main_vld;
    assign pcD    = main_pc;
    assign instD  = main_inst;
    assign stateD = main_st;

    // Main/skid entries: reset and flush empty both; a transfer refills main from
    // the older skid entry first, otherwise from the incoming offer.
    always_ff @(negedge CLK) begin
        if (RST || fail_predict) begin
            main_vld  <= 1'b0;
            main_pc   <= '0;
            main_inst <= '0;
            main_st   <= '0;
            skid_vld  <= 1'b0;
            skid_pc   <= '0;
            skid_inst <= '0;
            skid_st   <= '0;
        end else if (transfer) begin
            if (skid_vld) begin
                main_vld  <= 1'b1;
                main_pc   <= skid_pc;
                main_inst <= skid_inst;
                main_st   <= skid_st;
                skid_vld  <= 1'b0;
                skid_pc   <= '0;
                skid_inst <= '0;
                skid_st   <= '0;
            end else if (accept) begin
                main_vld  <= 1'b1;
                main_pc   <= pcC;
                main_inst <= instC;
                main_st   <= stateC;
            end else begin
                main_vld  <= 1'b0;
                main_pc   <= '0;
                main_inst <= '0;
                main_st   <= '0;
            end
        end else if (accept) begin
            if (!main_vld) begin
                main_vld  <= 1'b1;
                main_pc   <= pcC;
                main_inst <= instC;
                main_st   <= stateC;
            end else begin
                skid_vld  <= 1'b1;
                skid_pc   <= pcC;
                skid_inst <= instC;
                skid_st   <= stateC;
            end
        end
    end

`ifdef STAGE_BUF_PERF_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Performance counters: count stalled-output edges and flush edges, saturating.
    always_ff @(negedge CLK) begin
        if (RST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (main_vld && !readyD) stall_cnt <= sat_inc(stall_cnt);
            if (fail_predict)        flush_cnt <= sat_inc(flush_cnt);
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
